// File: rtl/uart_input_ctrl_if.sv
// Decode/UART-side signal bundle for uart_input_ctrl.
// master drives the request and receiver strobe; slave is the controller itself.
interface uart_input_ctrl_if;
   logic        in_req;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic [31:0] UART_in;
   logic        rx_signal;
   logic        stall;
   logic        overrun;
   logic        timeout;

   modport master (
      output in_req, rx_byte, rx_valid,
      input  UART_in, rx_signal, stall, overrun, timeout
   );

   modport slave (
      input  in_req, rx_byte, rx_valid,
      output UART_in, rx_signal, stall, overrun, timeout
   );
endinterface

// File: rtl/uart_input_ctrl.sv
// UART input instruction controller: stalls the pipeline while BYTES received bytes
// are packed little-endian into a 32-bit word, then presents it for one write cycle.
module uart_input_ctrl #(
   parameter int BYTES   = 4,
   parameter int TIMEOUT = 0
) (
   input  logic              clock,
   input  logic              reset,
   uart_input_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DELIVER = 2'd2
   } state_t;

   localparam logic [1:0]  LAST = 2'(BYTES - 1);
   localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [1:0]  cnt, cnt_nxt;
   logic [15:0] idle_cnt, idle_nxt;
   logic [31:0] word, word_nxt;
   logic        ovr, ovr_nxt;
   logic        tmo, tmo_nxt;
   logic        expire;

   // Expiry is judged on the cycle's starting count, so a byte arriving in that
   // same cycle is still taken before the short word is delivered.
   assign expire = (TIMEOUT != 0) && (idle_cnt == TLIM);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         idle_cnt <= '0;
         word     <= '0;
         ovr      <= 1'b0;
         tmo      <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         idle_cnt <= idle_nxt;
         word     <= word_nxt;
         ovr      <= ovr_nxt;
         tmo      <= tmo_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idle_nxt  = idle_cnt;
      word_nxt  = word;
      ovr_nxt   = ovr;
      tmo_nxt   = tmo;
      case (state)
         IDLE: begin
            if (bus.rx_valid) ovr_nxt = 1'b1;
            if (bus.in_req) begin
               cnt_nxt   = '0;
               idle_nxt  = '0;
               word_nxt  = '0;
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (bus.rx_valid) begin
               word_nxt[{cnt, 3'b000} +: 8] = bus.rx_byte;
               cnt_nxt  = cnt + 2'd1;
               idle_nxt = '0;
               if (cnt == LAST) begin
                  state_nxt = DELIVER;
               end else if (expire) begin
                  state_nxt = DELIVER;
                  tmo_nxt   = 1'b1;
               end
            end else if (expire) begin
               state_nxt = DELIVER;
               tmo_nxt   = 1'b1;
            end else begin
               idle_nxt = idle_cnt + 16'd1;
            end
         end
         DELIVER: begin
            if (bus.rx_valid) ovr_nxt = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.UART_in   = word;
   assign bus.overrun   = ovr;
   assign bus.timeout   = tmo;
   assign bus.stall     = (state == COLLECT);
   assign bus.rx_signal = (state == DELIVER);

endmodule

// File: tb/tb_uart_input_ctrl.sv
// Scoreboard bench: dut_a (BYTES=4, TIMEOUT=10) and dut_b (BYTES=2, no timeout)
// share clock/reset; a word model predicts each delivery, a monitor checks it.
module tb_uart_input_ctrl;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   uart_input_ctrl_if ifa ();
   uart_input_ctrl_if ifb ();

   uart_input_ctrl #(.BYTES(4), .TIMEOUT(10)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
   uart_input_ctrl #(.BYTES(2), .TIMEOUT(0))  dut_b (.clock(clock), .reset(reset), .bus(ifb));

   typedef struct {
      logic [31:0] word;
      logic        tflag;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   total = 0;
   int   bad   = 0;
   logic st_a = 1'b0, st_b = 1'b0;
   logic ov_a = 1'b0, ov_b = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] word_of(int d);
      return (d == 0) ? ifa.UART_in : ifb.UART_in;
   endfunction
   function automatic logic stall_of(int d);
      return (d == 0) ? ifa.stall : ifb.stall;
   endfunction
   function automatic logic rxs_of(int d);
      return (d == 0) ? ifa.rx_signal : ifb.rx_signal;
   endfunction
   function automatic logic ovr_of(int d);
      return (d == 0) ? ifa.overrun : ifb.overrun;
   endfunction
   function automatic logic tmo_of(int d);
      return (d == 0) ? ifa.timeout : ifb.timeout;
   endfunction

   // One clock cycle with the given inputs; es/er < 0 skip the stall/rx_signal check.
   task automatic cyc(int d, logic req, logic v, logic [7:0] b, int es, int er);
      if (d == 0) begin
         ifa.in_req = req; ifa.rx_valid = v; ifa.rx_byte = b;
      end else begin
         ifb.in_req = req; ifb.rx_valid = v; ifb.rx_byte = b;
      end
      @(negedge clock);
      if (es >= 0) chk((d == 0) ? "a_stall" : "b_stall", 32'(stall_of(d)), 32'(es));
      if (er >= 0) chk((d == 0) ? "a_rx_signal" : "b_rx_signal", 32'(rxs_of(d)), 32'(er));
      @(posedge clock);
      #1;
   endtask

   // Issue one input instruction; the model decides which bytes make it into the word.
   task automatic xact(int d, logic [7:0] bytes[4], int gaps[4], bit hold, bit dv);
      int          nb, lim, used, tail;
      logic [31:0] w;
      bit          tf;
      exp_t        e;
      nb = (d == 0) ? 4 : 2;
      lim = (d == 0) ? 10 : 0;
      w = '0; tf = 1'b0; used = 0; tail = 0;
      for (int i = 0; i < nb; i++) begin
         if (lim > 0 && gaps[i] >= lim) begin
            tf = 1'b1; tail = lim;
            break;
         end
         w[8*i +: 8] = bytes[i];
         used = i + 1;
         if (lim > 0 && gaps[i] == lim - 1 && i != nb - 1) begin
            tf = 1'b1;
            break;
         end
      end
      e.word = w;
      if (d == 0) begin
         st_a = st_a | tf; e.tflag = st_a; qa.push_back(e);
      end else begin
         st_b = st_b | tf; e.tflag = st_b; qb.push_back(e);
      end
      cyc(d, 1'b1, 1'b0, 8'h00, 0, 0);
      chk((d == 0) ? "a_clear_on_entry" : "b_clear_on_entry", word_of(d), 32'h0);
      for (int i = 0; i < used; i++) begin
         for (int k = 0; k < gaps[i]; k++) cyc(d, hold, 1'b0, 8'h00, 1, 0);
         cyc(d, hold, 1'b1, bytes[i], 1, 0);
      end
      for (int k = 0; k < tail; k++) cyc(d, hold, 1'b0, 8'h00, 1, 0);
      cyc(d, hold, dv, 8'h99, 0, 1);
      if (dv) begin
         if (d == 0) ov_a = 1'b1; else ov_b = 1'b1;
      end
      chk((d == 0) ? "a_overrun" : "b_overrun", 32'(ovr_of(d)), 32'((d == 0) ? ov_a : ov_b));
      if (d == 0) begin
         ifa.rx_valid = 1'b0; ifa.in_req = hold;
      end else begin
         ifb.rx_valid = 1'b0; ifb.in_req = hold;
      end
   endtask

   always @(negedge clock) begin
      if (ifa.rx_signal === 1'b1) begin
         if (qa.size() == 0) begin
            total++; bad++;
            $display("FAIL a_unexpected: got word %h want no delivery", ifa.UART_in);
         end else begin
            ea = qa.pop_front();
            chk("a_word", ifa.UART_in, ea.word);
            chk("a_timeout", 32'(ifa.timeout), 32'(ea.tflag));
         end
      end
      if (ifb.rx_signal === 1'b1) begin
         if (qb.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected: got word %h want no delivery", ifb.UART_in);
         end else begin
            eb = qb.pop_front();
            chk("b_word", ifb.UART_in, eb.word);
            chk("b_timeout", 32'(ifb.timeout), 32'(eb.tflag));
         end
      end
   end

   logic [7:0] bv[4];
   int         gv[4];
   int         d, dnext;
   bit         hold, dv;

   initial begin
      ifa.in_req = 1'b0; ifa.rx_valid = 1'b0; ifa.rx_byte = 8'h00;
      ifb.in_req = 1'b0; ifb.rx_valid = 1'b0; ifb.rx_byte = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_word", word_of(k), 32'h0);
         chk("rst_stall", 32'(stall_of(k)), 32'h0);
         chk("rst_rx_signal", 32'(rxs_of(k)), 32'h0);
         chk("rst_overrun", 32'(ovr_of(k)), 32'h0);
         chk("rst_timeout", 32'(tmo_of(k)), 32'h0);
      end
      reset = 1'b1;

      bv = '{8'h11, 8'h22, 8'h33, 8'h44}; gv = '{2, 3, 1, 4};
      xact(0, bv, gv, 1'b0, 1'b0);

      bv = '{8'h12, 8'h34, 8'h00, 8'h00}; gv = '{1, 5, 0, 0};
      xact(1, bv, gv, 1'b1, 1'b0);
      bv = '{8'hAB, 8'hCD, 8'h00, 8'h00}; gv = '{0, 2, 0, 0};
      xact(1, bv, gv, 1'b0, 1'b0);
      chk("b_b2b_overrun", 32'(ifb.overrun), 32'h0);
      cyc(1, 1'b0, 1'b1, 8'h77, 0, 0);
      ov_b = 1'b1;
      chk("b_idle_overrun", 32'(ifb.overrun), 32'h1);
      chk("b_word_hold", ifb.UART_in, 32'h0000CDAB);
      cyc(1, 1'b0, 1'b0, 8'h00, 0, 0);

      cyc(0, 1'b0, 1'b1, 8'h55, 0, 0);
      ov_a = 1'b1;
      chk("a_idle_overrun", 32'(ifa.overrun), 32'h1);
      chk("a_idle_stall", 32'(ifa.stall), 32'h0);
      cyc(0, 1'b0, 1'b0, 8'h00, 0, 0);

      bv = '{8'h5A, 8'h00, 8'h00, 8'h00}; gv = '{0, 20, 0, 0};
      xact(0, bv, gv, 1'b0, 1'b0);
      bv = '{8'h01, 8'h02, 8'h03, 8'h04}; gv = '{15, 0, 0, 0};
      xact(0, bv, gv, 1'b0, 1'b0);
      bv = '{8'hA1, 8'hB2, 8'hC3, 8'hD4}; gv = '{0, 9, 0, 0};
      xact(0, bv, gv, 1'b0, 1'b1);
      bv = '{8'h10, 8'h20, 8'h30, 8'h40}; gv = '{3, 0, 1, 9};
      xact(0, bv, gv, 1'b0, 1'b0);

      cyc(0, 1'b1, 1'b0, 8'h00, 0, 0);
      cyc(0, 1'b0, 1'b1, 8'hEF, 1, 0);
      cyc(0, 1'b0, 1'b1, 8'hBE, 1, 0);
      ifa.rx_valid = 1'b0;
      chk("a_partial", ifa.UART_in, 32'h0000BEEF);
      #2 reset = 1'b0;
      #1;
      chk("arst_word", ifa.UART_in, 32'h0);
      chk("arst_stall", 32'(ifa.stall), 32'h0);
      chk("arst_overrun", 32'(ifa.overrun), 32'h0);
      chk("arst_timeout", 32'(ifa.timeout), 32'h0);
      chk("arst_b_overrun", 32'(ifb.overrun), 32'h0);
      st_a = 1'b0; st_b = 1'b0; ov_a = 1'b0; ov_b = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      bv = '{8'hEF, 8'hBE, 8'hAD, 8'hDE}; gv = '{0, 1, 2, 0};
      xact(0, bv, gv, 1'b0, 1'b0);

      dnext = -1;
      for (int n = 0; n < 40; n++) begin
         d = (dnext >= 0) ? dnext : int'($urandom_range(0, 1));
         hold = (n != 39) && ($urandom_range(0, 3) == 0);
         dv = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < 4; i++) begin
            bv[i] = 8'($urandom);
            gv[i] = int'($urandom_range(0, 13));
         end
         xact(d, bv, gv, hold, dv);
         dnext = hold ? d : -1;
      end

      repeat (3) @(posedge clock);
      #1;
      chk("a_pending", 32'(qa.size()), 32'h0);
      chk("b_pending", 32'(qb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_input_ctrl.md
UART_INPUT_CTRL -- requirements
Module: uart_input_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter BYTES, default 4, giving the number of received bytes assembled per word; legal values are 1 to 4.
REQ-002 The block SHALL have parameter TIMEOUT, default 0, giving the idle-cycle limit between bytes during collection; 0 disables the timeout; legal values are 0 to 65535.

Ports:
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_req  input  1  level signal from decode; high means the current instruction is an UART input instruction.
REQ-006 rx_byte  input  8  received byte from the UART receiver; valid only while rx_valid is high.
REQ-007 rx_valid  input  1  one-cycle strobe meaning rx_byte holds a new byte.
REQ-008 UART_in  output  32  assembled word, driven to the register-write input mux.
REQ-009 rx_signal  output  1  mux select; high selects UART_in as the register write data.
REQ-010 stall  output  1  high holds the PC and the pipeline.
REQ-011 overrun  output  1  sticky flag; a byte was dropped.
REQ-012 timeout  output  1  sticky flag; a word was delivered short because of the timeout.

Function
REQ-013 The FSM SHALL have three states: IDLE, COLLECT and DELIVER; all outputs SHALL be registered except stall and rx_signal, which SHALL decode the state combinationally.
REQ-014 In IDLE, stall and rx_signal SHALL be 0; in_req=1 SHALL clear the byte counter and UART_in to 0 and move the FSM to COLLECT on the next edge.
REQ-015 In COLLECT, stall SHALL be 1 and rx_signal SHALL be 0; in_req SHALL be ignored.
REQ-016 In COLLECT, rx_valid=1 SHALL write rx_byte into UART_in[8*cnt+7:8*cnt] and increment cnt; the first byte lands in bits [7:0] (little-endian); bytes not yet received SHALL stay 0.
REQ-017 In COLLECT, rx_valid=1 with cnt=BYTES-1 SHALL write that byte and move the FSM to DELIVER on the same edge.
REQ-018 DELIVER SHALL last exactly one cycle with rx_signal=1 and stall=0, so the register write and the PC advance share the closing edge; the FSM then returns to IDLE.
REQ-019 UART_in SHALL hold the last delivered word until the next IDLE to COLLECT transition.
REQ-020 When TIMEOUT>0, a 16-bit idle counter SHALL reset on each accepted byte and on COLLECT entry, and SHALL increment on every other COLLECT cycle; when it reaches TIMEOUT, the FSM SHALL go to DELIVER with the partial word and set timeout.
REQ-021 A zero-byte timeout SHALL deliver 0x00000000.
REQ-022 rx_valid=1 in IDLE or DELIVER SHALL drop the byte and set overrun.
REQ-023 If rx_valid and the timeout expire in the same COLLECT cycle, the byte SHALL be accepted; timeout SHALL be set only if the word is still short after that byte.
REQ-024 If in_req=1 in the IDLE cycle directly after DELIVER, a new collection SHALL start; back-to-back input instructions SHALL need no gap cycle.
REQ-025 overrun and timeout SHALL be cleared only by reset.

Reset
REQ-026 reset=0 SHALL immediately force: state IDLE, cnt=0, idle counter=0, UART_in=0x00000000, rx_signal=0, stall=0, overrun=0, timeout=0; this applies mid-collection too, and partial data SHALL be discarded.
REQ-027 After reset deasserts, the block SHALL accept in_req on the first rising edge.

Verification
REQ-028 BYTES=4: in_req=1, then bytes 0x11, 0x22, 0x33, 0x44 with gaps -> stall=1 throughout collection; one DELIVER cycle with rx_signal=1, stall=0, UART_in=0x44332211; then IDLE.
REQ-029 BYTES=2: bytes 0xAB, 0xCD -> UART_in=0x0000CDAB; rx_valid=1 on the cycle after DELIVER -> overrun=1, UART_in unchanged.
REQ-030 TIMEOUT=10, BYTES=4: in_req=1, byte 0x5A, then no rx_valid -> DELIVER 10 idle cycles after the byte; UART_in=0x0000005A, timeout=1.
REQ-031 reset=0 asserted after 2 of 4 bytes -> outputs clear asynchronously, before the next edge; after release, a fresh 4-byte sequence 0xDEADBEEF (bytes EF, BE, AD, DE) delivers correctly.
REQ-032 Two input instructions back-to-back, with in_req held high across DELIVER -> second COLLECT entered on the cycle after DELIVER and UART_in cleared to 0 on entry; both words delivered, no overrun.
REQ-033 rx_valid=1 in IDLE with in_req=0 -> byte dropped, overrun=1, stall stays 0.
